// File: rtl/cwc_capture_ctrl.sv
// Logic-analyser capture controller: keeps a pre-trigger history in a circular
// capture RAM, waits for a trigger, then fills the remaining depth with post-trigger samples.
module cwc_capture_ctrl #(
  parameter int DATA_W = 167,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] din,
  input  logic              trig,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [2:0]        state,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_t            state_q, state_d;
  wr_t               wr_q, wr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] plen_q, plen_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] pre_inc;
  logic              wr_en;

  assign pre_inc = pre_q + 1'b1;

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    plen_d  = plen_q;
    pre_d   = pre_q;
    post_d  = post_q;
    trig_d  = trig_q;
    start_d = start_q;
    done_d  = done_q;
    wr_en   = 1'b0;

    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            plen_d  = pretrig_len;
            waddr_d = '0;
            pre_d   = '0;
            trig_d  = '0;
            start_d = '0;
            done_d  = 1'b0;
            state_d = (pretrig_len != '0) ? PRE : WAIT;
          end
        end
        PRE: begin
          if (sample_en) begin
            wr_en   = 1'b1;
            waddr_d = waddr_q + 1'b1;
            pre_d   = pre_inc;
            if (pre_inc == plen_q) state_d = WAIT;
          end
        end
        WAIT: begin
          if (sample_en) begin
            wr_en   = 1'b1;
            waddr_d = waddr_q + 1'b1;
            if (trig) begin
              trig_d  = waddr_q;
              start_d = waddr_q - plen_q;
              // DEPTH-1-plen in ADDR_W bits is simply the complement of plen.
              post_d  = ~plen_q;
              if (~plen_q != '0) begin
                state_d = POST;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        POST: begin
          if (sample_en) begin
            wr_en   = 1'b1;
            waddr_d = waddr_q + 1'b1;
            post_d  = post_q - 1'b1;
            if (post_q == ADDR_W'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Address/data hold their last value between writes; only we pulses.
  always_comb begin
    wr_d    = wr_q;
    wr_d.we = wr_en;
    if (wr_en) begin
      wr_d.addr = waddr_q;
      wr_d.data = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      waddr_q <= '0;
      plen_q  <= '0;
      pre_q   <= '0;
      post_q  <= '0;
      trig_q  <= '0;
      start_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      plen_q  <= plen_d;
      pre_q   <= pre_d;
      post_q  <= post_d;
      trig_q  <= trig_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign ram_we     = wr_q.we;
  assign ram_waddr  = wr_q.addr;
  assign ram_wdata  = wr_q.data;
  assign state      = state_q;
  assign done       = done_q;
  assign trig_addr  = trig_q;
  assign start_addr = start_q;

endmodule
